alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameters SHALL be: ACTION_LEN, default 64, action word width; DATA_WIDTH, default 32, operand/result width; STAGE_ID, default 0, pipeline stage index; TIMEOUT, default 255, max cycles waiting for an ALU result.
REQ-002 Clock and reset SHALL be: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 Upstream ports SHALL be: req_action  in  ACTION_LEN  action word; req_op1/req_op2/req_op3  in  DATA_WIDTH each  operands; req_vid  in  4  tenant id; req_valid  in  1  request valid; req_ready  out  1  request accepted.
REQ-004 Config ports SHALL be: cfg_wr_en  in  1  page-table write; cfg_wr_vid  in  4  entry index; cfg_wr_data  in  16  {addr_len[15:8], base_addr[7:0]}.
REQ-005 ALU-side ports SHALL be: action_out  out  ACTION_LEN; operand_1_out/operand_2_out/operand_3_out  out  DATA_WIDTH each; action_valid  out  1  issue pulse; page_tbl_out  out  16; page_tbl_out_valid  out  1; alu_ready  in  1  ALU idle; container_in  in  DATA_WIDTH  ALU result; container_in_valid  in  1  result pulse; alu_res_ready  out  1  result acceptable.
REQ-006 Downstream/status ports SHALL be: res_data  out  DATA_WIDTH; res_valid  out  1; res_ready  in  1; busy  out  1  FSM not IDLE; err_timeout  out  1  sticky timeout flag.

Function
REQ-007 FSM states SHALL be IDLE, LOOKUP, ISSUE, WAIT; at most one ALU operation outstanding.
REQ-008 req_ready SHALL be 1 only in IDLE with res_valid=0; handshake req_valid&req_ready captures action, operands, vid into registers and moves to LOOKUP.
REQ-009 LOOKUP SHALL read the 16-entry page table at captured vid, register the entry onto page_tbl_out, assert page_tbl_out_valid, and move to ISSUE after 1 cycle.
REQ-010 A cfg write to the same vid in the LOOKUP cycle SHALL be write-first: the new cfg_wr_data is used.
REQ-011 In ISSUE, when alu_ready=1, action_valid SHALL pulse high for exactly one cycle with action_out/operands/page_tbl_out stable, then state SHALL move to WAIT; when alu_ready=0 the block SHALL hold in ISSUE with action_valid=0.
REQ-012 action_out, operand_*_out and page_tbl_out SHALL stay stable from ISSUE entry until return to IDLE.
REQ-013 alu_res_ready SHALL equal ~res_valid in every state, so the ALU stalls while a result is pending downstream.
REQ-014 In WAIT, container_in_valid&alu_res_ready SHALL register container_in into res_data, set res_valid, clear page_tbl_out_valid and return to IDLE the next cycle.
REQ-015 res_valid SHALL hold with res_data stable until res_valid&res_ready; it clears the following cycle.
REQ-016 A WAIT counter SHALL start at 0 on WAIT entry, increment per cycle, and on reaching TIMEOUT without a result set err_timeout, return to IDLE, produce no result.
REQ-017 container_in_valid outside WAIT SHALL be ignored (late result after timeout dropped).
REQ-018 err_timeout SHALL clear only on reset.
REQ-019 Total latency from request accept to res_valid SHALL be 3 cycles plus ALU-ready stall plus ALU result latency.

Reset
REQ-020 On rst_n=0 (asynchronous): state=IDLE; req_ready=1; action_valid, page_tbl_out_valid, res_valid, err_timeout, busy=0; alu_res_ready=1; all data outputs and page-table entries=0.
REQ-021 Reset mid-operation SHALL abandon the in-flight operation with no result emitted.

Structure
REQ-022 State encodings, page-table field widths (base 8, len 8) and VID width SHALL live in a shared rmt package.
REQ-023 The page table SHALL be a sub-module alu_page_tbl (16x16 regfile, 1 write port, registered read with write-first bypass).

Verification
REQ-024 Write vid 3={len 8, base 0x10}; request vid 3, op1=5, op2=7, alu_ready=1, ALU returns 12 two cycles after action_valid -> single action_valid pulse, page_tbl_out=0x0810, res_data=12.
REQ-025 alu_ready=0 for 10 cycles in ISSUE -> action_valid stays 0, outputs stable; pulses once on alu_ready=1.
REQ-026 res_ready=0 for 5 cycles after result -> res_valid/res_data held, req_ready=0, alu_res_ready=0; accept resumes next cycle after handshake.
REQ-027 No ALU result for 255 WAIT cycles -> err_timeout=1, state IDLE; late container_in_valid ignored, res_valid stays 0.
REQ-028 cfg write vid 5 in LOOKUP cycle for vid 5 -> page_tbl_out equals new data; rst_n pulse in WAIT -> all outputs at reset values, no result.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: FSM encoding, tenant id width
// and the page-table entry layout.
package alu_issue_ctrl_pkg;

    localparam int VID_W    = 4;
    localparam int BASE_W   = 8;
    localparam int LEN_W    = 8;
    localparam int PTE_W    = LEN_W + BASE_W;
    localparam int PT_DEPTH = 1 << VID_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  addr_len;
        logic [BASE_W-1:0] base_addr;
    } pte_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// ALU-side bus between the issue controller (master) and the ALU (slave).
interface alu_issue_ctrl_if #(
    parameter int ACTION_LEN = 64,
    parameter int DATA_WIDTH = 32
);
    import alu_issue_ctrl_pkg::*;

    logic [ACTION_LEN-1:0] action_out;
    logic [DATA_WIDTH-1:0] operand_1_out;
    logic [DATA_WIDTH-1:0] operand_2_out;
    logic [DATA_WIDTH-1:0] operand_3_out;
    logic                  action_valid;
    logic [PTE_W-1:0]      page_tbl_out;
    logic                  page_tbl_out_valid;
    logic                  alu_ready;
    logic [DATA_WIDTH-1:0] container_in;
    logic                  container_in_valid;
    logic                  alu_res_ready;

    modport master (
        output action_out, operand_1_out, operand_2_out, operand_3_out,
        output action_valid, page_tbl_out, page_tbl_out_valid, alu_res_ready,
        input  alu_ready, container_in, container_in_valid
    );

    modport slave (
        input  action_out, operand_1_out, operand_2_out, operand_3_out,
        input  action_valid, page_tbl_out, page_tbl_out_valid, alu_res_ready,
        output alu_ready, container_in, container_in_valid
    );

endinterface

// File: rtl/alu_page_tbl.sv
// Per-tenant page table: 16 entries, one write port, registered read that
// returns same-cycle write data when the addresses collide.
module alu_page_tbl
    import alu_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [VID_W-1:0] wr_vid,
    input  pte_t             wr_data,
    input  logic             rd_en,
    input  logic [VID_W-1:0] rd_vid,
    output pte_t             rd_data
);

    pte_t entries [PT_DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: entries are reset so an unconfigured tenant reads as an all-zero page.
            for (int i = 0; i < PT_DEPTH; i++) begin
                entries[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                entries[wr_vid] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= (wr_en && (wr_vid == rd_vid)) ? wr_data : entries[rd_vid];
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation at a time: capture request, look up the tenant page,
// issue to the ALU, wait (bounded) for the result and hold it for downstream.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int ACTION_LEN = 64,
    parameter int DATA_WIDTH = 32,
    parameter int STAGE_ID   = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACTION_LEN-1:0] req_action,
    input  logic [DATA_WIDTH-1:0] req_op1,
    input  logic [DATA_WIDTH-1:0] req_op2,
    input  logic [DATA_WIDTH-1:0] req_op3,
    input  logic [VID_W-1:0]      req_vid,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  cfg_wr_en,
    input  logic [VID_W-1:0]      cfg_wr_vid,
    input  logic [PTE_W-1:0]      cfg_wr_data,
    alu_issue_ctrl_if.master      alu,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    if (TIMEOUT < 1 || STAGE_ID < 0) begin : g_param_check
        $error("alu_issue_ctrl: TIMEOUT must be >= 1 and STAGE_ID non-negative");
    end

    state_e           state;
    logic [VID_W-1:0] vid_q;
    logic [CNT_W-1:0] wait_cnt;
    pte_t             pte_rd;

    alu_page_tbl u_page_tbl (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_wr_en),
        .wr_vid  (cfg_wr_vid),
        .wr_data (cfg_wr_data),
        .rd_en   (state == ST_LOOKUP),
        .rd_vid  (vid_q),
        .rd_data (pte_rd)
    );

    assign req_ready          = (state == ST_IDLE) && !res_valid;
    assign busy               = (state != ST_IDLE);
    assign alu.alu_res_ready  = !res_valid;
    assign alu.page_tbl_out   = pte_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= ST_IDLE;
            vid_q                  <= '0;
            wait_cnt               <= '0;
            alu.action_out         <= '0;
            alu.operand_1_out      <= '0;
            alu.operand_2_out      <= '0;
            alu.operand_3_out      <= '0;
            alu.action_valid       <= 1'b0;
            alu.page_tbl_out_valid <= 1'b0;
            res_data               <= '0;
            res_valid              <= 1'b0;
            err_timeout            <= 1'b0;
        end else begin
            alu.action_valid <= 1'b0;
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        alu.action_out    <= req_action;
                        alu.operand_1_out <= req_op1;
                        alu.operand_2_out <= req_op2;
                        alu.operand_3_out <= req_op3;
                        vid_q             <= req_vid;
                        state             <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    alu.page_tbl_out_valid <= 1'b1;
                    state                  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (alu.alu_ready) begin
                        alu.action_valid <= 1'b1;
                        wait_cnt         <= '0;
                        state            <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Result wins over a timeout landing in the same cycle.
                    if (alu.container_in_valid && alu.alu_res_ready) begin
                        res_data               <= alu.container_in;
                        res_valid              <= 1'b1;
                        alu.page_tbl_out_valid <= 1'b0;
                        state                  <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_timeout            <= 1'b1;
                        alu.page_tbl_out_valid <= 1'b0;
                        state                  <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl: stimulus pushes expected results,
// a monitor pops them on each downstream handshake.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] req_action;
    logic [DW-1:0] req_op1, req_op2, req_op3;
    logic [3:0]    req_vid;
    logic          req_valid;
    logic          req_ready;
    logic          cfg_wr_en;
    logic [3:0]    cfg_wr_vid;
    logic [15:0]   cfg_wr_data;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
    logic          err_timeout;

    alu_issue_ctrl_if #(.ACTION_LEN(AW), .DATA_WIDTH(DW)) alu_bus ();

    alu_issue_ctrl #(
        .ACTION_LEN (AW),
        .DATA_WIDTH (DW),
        .STAGE_ID   (0),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_action  (req_action),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_op3     (req_op3),
        .req_vid     (req_vid),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_wr_vid  (cfg_wr_vid),
        .cfg_wr_data (cfg_wr_data),
        .alu         (alu_bus),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q [$];
    int            pulses    = 0;
    int            alu_lat   = 2;
    bit            alu_en    = 1'b1;
    int            late_req  = 0;
    int            late_done = 0;
    logic [DW-1:0] alu_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (alu_bus.action_valid) pulses++;
    end

    // ALU model: returns op1+op2 alu_lat cycles after an issue pulse.
    initial begin
        alu_bus.container_in       = '0;
        alu_bus.container_in_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (late_req != late_done) begin
                late_done++;
                alu_bus.container_in       = 32'd99;
                alu_bus.container_in_valid = 1'b1;
                @(negedge clk);
                alu_bus.container_in_valid = 1'b0;
            end else if (alu_bus.action_valid && alu_en) begin
                alu_r = alu_bus.operand_1_out + alu_bus.operand_2_out;
                repeat (alu_lat) @(negedge clk);
                alu_bus.container_in       = alu_r;
                alu_bus.container_in_valid = 1'b1;
                @(negedge clk);
                alu_bus.container_in_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: compare on every downstream handshake.
    always begin
        @(negedge clk);
        #2;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", 64'(exp_q.size() != 0), 64'd1);
            else                   check("res_data", res_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"},     req_ready, 1);
        check({tag, "_busy"},          busy, 0);
        check({tag, "_action_valid"},  alu_bus.action_valid, 0);
        check({tag, "_ptv"},           alu_bus.page_tbl_out_valid, 0);
        check({tag, "_res_valid"},     res_valid, 0);
        check({tag, "_err_timeout"},   err_timeout, 0);
        check({tag, "_alu_res_ready"}, alu_bus.alu_res_ready, 1);
        check({tag, "_action_out"},    alu_bus.action_out, 0);
        check({tag, "_operand_1"},     alu_bus.operand_1_out, 0);
        check({tag, "_page_tbl_out"},  alu_bus.page_tbl_out, 0);
        check({tag, "_res_data"},      res_data, 0);
    endtask

    task automatic cfg_write(input logic [3:0] vid, input logic [15:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_vid  = vid;
        cfg_wr_data = data;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send_req(input logic [63:0] act, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [3:0] vid);
        int guard = 0;
        req_action = act;
        req_op1    = a;
        req_op2    = b;
        req_op3    = c;
        req_vid    = vid;
        req_valid  = 1'b1;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || res_valid) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reached", 64'(busy || res_valid), 0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int bad;
        int p0;

        rst_n                = 1'b0;
        req_action           = '0;
        req_op1              = '0;
        req_op2              = '0;
        req_op3              = '0;
        req_vid              = '0;
        req_valid            = 1'b0;
        cfg_wr_en            = 1'b0;
        cfg_wr_vid           = '0;
        cfg_wr_data          = '0;
        res_ready            = 1'b1;
        alu_bus.alu_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic issue: vid 3 = {len 8, base 0x10}, 5+7 returned two cycles after issue.
        cfg_write(4'd3, 16'h0810);
        alu_bus.alu_ready = 1'b1;
        alu_lat = 2;
        p0 = pulses;
        exp_q.push_back(32'd12);
        send_req(64'h0000_0000_0000_00A5, 32'd5, 32'd7, 32'd0, 4'd3);
        check("t1_busy_in_lookup", busy, 1);
        check("t1_req_ready_busy", req_ready, 0);
        @(negedge clk);
        check("t1_ptv", alu_bus.page_tbl_out_valid, 1);
        check("t1_page_tbl_out", alu_bus.page_tbl_out, 16'h0810);
        check("t1_action_out", alu_bus.action_out, 64'hA5);
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("t1_latency", lat, 5);
        check("t1_ptv_cleared", alu_bus.page_tbl_out_valid, 0);
        wait_idle();
        check("t1_issue_pulses", pulses - p0, 1);

        // ALU busy for 10 cycles in ISSUE.
        cfg_write(4'd4, 16'h2040);
        alu_bus.alu_ready = 1'b0;
        alu_lat = 1;
        p0 = pulses;
        exp_q.push_back(32'd123);
        send_req(64'hDEAD_BEEF_0000_0001, 32'd100, 32'd23, 32'd9, 4'd4);
        @(negedge clk);
        check("t2_page_tbl_out", alu_bus.page_tbl_out, 16'h2040);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (alu_bus.action_valid || alu_bus.action_out != 64'hDEAD_BEEF_0000_0001 ||
                alu_bus.operand_1_out != 32'd100 || alu_bus.operand_2_out != 32'd23 ||
                alu_bus.operand_3_out != 32'd9 || alu_bus.page_tbl_out != 16'h2040 || !busy)
                bad++;
        end
        check("t2_stall_violations", bad, 0);
        check("t2_pulses_during_stall", pulses - p0, 0);
        alu_bus.alu_ready = 1'b1;
        wait_idle();
        check("t2_issue_pulses", pulses - p0, 1);

        // Downstream back-pressure for 5 cycles.
        res_ready = 1'b0;
        exp_q.push_back(32'd42);
        send_req(64'h3, 32'd30, 32'd12, 32'd0, 4'd3);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!res_valid || res_data != 32'd42 || req_ready || alu_bus.alu_res_ready) bad++;
            @(negedge clk);
        end
        check("t3_hold_violations", bad, 0);
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_res_valid_cleared", res_valid, 0);
        check("t3_req_ready_resumed", req_ready, 1);
        check("t3_alu_res_ready", alu_bus.alu_res_ready, 1);

        // Timeout after exactly TIMEOUT WAIT cycles, late result dropped.
        alu_en = 1'b0;
        send_req(64'h4, 32'd1, 32'd1, 32'd0, 4'd3);
        repeat (TMO + 1) @(negedge clk);
        check("t4_err_before_limit", err_timeout, 0);
        check("t4_busy_before_limit", busy, 1);
        @(negedge clk);
        check("t4_err_at_limit", err_timeout, 1);
        check("t4_idle_at_limit", busy, 0);
        check("t4_ptv_cleared", alu_bus.page_tbl_out_valid, 0);
        late_req++;
        repeat (6) @(negedge clk);
        check("t4_late_res_valid", res_valid, 0);
        check("t4_late_busy", busy, 0);
        check("t4_err_sticky", err_timeout, 1);

        // Write-first: cfg write to vid 5 during its LOOKUP cycle.
        alu_en = 1'b1;
        cfg_write(4'd5, 16'h1111);
        exp_q.push_back(32'd15);
        send_req(64'h5, 32'd7, 32'd8, 32'd0, 4'd5);
        cfg_wr_en   = 1'b1;
        cfg_wr_vid  = 4'd5;
        cfg_wr_data = 16'h3377;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
        check("t5_write_first", alu_bus.page_tbl_out, 16'h3377);
        check("t5_ptv", alu_bus.page_tbl_out_valid, 1);
        wait_idle();
        check("t5_err_still_sticky", err_timeout, 1);

        // Reset while WAITing: operation abandoned, table cleared.
        alu_en = 1'b0;
        send_req(64'h6, 32'd2, 32'd3, 32'd0, 4'd3);
        repeat (3) @(negedge clk);
        check("t6_busy_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset("t6_rst");
        @(negedge clk);
        rst_n  = 1'b1;
        alu_en = 1'b1;
        exp_q.push_back(32'd5);
        send_req(64'h7, 32'd2, 32'd3, 32'd0, 4'd3);
        @(negedge clk);
        check("t6_table_cleared", alu_bus.page_tbl_out, 16'h0000);
        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
